// File: rtl/dtw_accel_axil_mst_pkg.sv
// Shared constants for the DTW accelerator AXI4-Lite master: AXI response codes
// and the watchdog counter sizing helper.
package dtw_accel_axil_mst_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Counter must hold TIMEOUT_CYCLES itself; a disabled watchdog still needs one bit.
  function automatic int unsigned wdt_width(input int unsigned timeout_cycles);
    if (timeout_cycles < 2)
      return 1;
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/dtw_accel_axil_wdt.sv
// Per-transaction watchdog: loadable down-counter with clear and enable, emitting
// a single-cycle expire pulse TIMEOUT_CYCLES enabled cycles after the load.
module dtw_accel_axil_wdt
  import dtw_accel_axil_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = wdt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_load)
      r_count <= CW'(TIMEOUT_CYCLES);
    else if (i_en && (r_count != '0))
      r_count <= r_count - CW'(1);
  end

  // Counter parks at zero after expiring, so the pulse fires once; a zero limit never fires.
  always_comb begin
    o_expire = i_en && (r_count == CW'(1));
  end

endmodule

// File: rtl/dtw_accel_axil_mst.sv
// AXI4-Lite master: converts single register commands into one AXI4-Lite read or
// write at a time and returns the response (or a watchdog timeout) on a valid/ready channel.
module dtw_accel_axil_mst
  import dtw_accel_axil_mst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_RSP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                    w_cmd_hs;
  logic                    w_aw_pend;
  logic                    w_w_pend;
  logic                    w_b_hs;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_wdt_clr;
  logic                    w_wdt_load;
  logic                    w_wdt_en;
  logic                    w_expire;

  logic                    w_cmd_ready_nxt;
  logic                    w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
  logic [1:0]              w_rsp_resp_nxt;
  logic                    w_rsp_timeout_nxt;
  logic                    w_awvalid_nxt;
  logic [ADDR_WIDTH-1:0]   w_awaddr_nxt;
  logic                    w_wvalid_nxt;
  logic [DATA_WIDTH-1:0]   w_wdata_nxt;
  logic [STROBE_WIDTH-1:0] w_wstrb_nxt;
  logic                    w_bready_nxt;
  logic                    w_arvalid_nxt;
  logic [ADDR_WIDTH-1:0]   w_araddr_nxt;
  logic                    w_rready_nxt;

  always_comb begin
    w_cmd_hs  = i_cmd_valid && o_cmd_ready;
    w_aw_pend = o_awvalid && !i_awready;
    w_w_pend  = o_wvalid && !i_wready;
    w_b_hs    = i_bvalid && o_bready;
    w_ar_hs   = o_arvalid && i_arready;
    w_r_hs    = i_rvalid && o_rready;
    w_wdt_en  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    w_wdt_load = (r_state == S_IDLE) && w_cmd_hs;
    w_wdt_clr  = (r_state == S_IDLE) && !w_cmd_hs;
  end

  dtw_accel_axil_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_wdt_clr),
    .i_load   (w_wdt_load),
    .i_en     (w_wdt_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_rsp_timeout <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= '0;
      o_wvalid      <= 1'b0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_araddr      <= '0;
      o_rready      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      o_cmd_ready   <= w_cmd_ready_nxt;
      o_rsp_valid   <= w_rsp_valid_nxt;
      o_rsp_rdata   <= w_rsp_rdata_nxt;
      o_rsp_resp    <= w_rsp_resp_nxt;
      o_rsp_timeout <= w_rsp_timeout_nxt;
      o_awvalid     <= w_awvalid_nxt;
      o_awaddr      <= w_awaddr_nxt;
      o_wvalid      <= w_wvalid_nxt;
      o_wdata       <= w_wdata_nxt;
      o_wstrb       <= w_wstrb_nxt;
      o_bready      <= w_bready_nxt;
      o_arvalid     <= w_arvalid_nxt;
      o_araddr      <= w_araddr_nxt;
      o_rready      <= w_rready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_cmd_hs) w_state_nxt = i_cmd_wr ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if (!w_aw_pend && !w_w_pend) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (w_b_hs) w_state_nxt = S_RSP;
      S_RD_REQ:  if (w_ar_hs) w_state_nxt = S_RD_RESP;
      S_RD_RESP: if (w_r_hs) w_state_nxt = S_RSP;
      S_RSP:     if (i_rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_expire)
      w_state_nxt = S_RSP;
  end

  always_comb begin
    w_cmd_ready_nxt   = 1'b0;
    w_rsp_valid_nxt   = o_rsp_valid;
    w_rsp_rdata_nxt   = o_rsp_rdata;
    w_rsp_resp_nxt    = o_rsp_resp;
    w_rsp_timeout_nxt = o_rsp_timeout;
    w_awvalid_nxt     = o_awvalid;
    w_awaddr_nxt      = o_awaddr;
    w_wvalid_nxt      = o_wvalid;
    w_wdata_nxt       = o_wdata;
    w_wstrb_nxt       = o_wstrb;
    w_bready_nxt      = o_bready;
    w_arvalid_nxt     = o_arvalid;
    w_araddr_nxt      = o_araddr;
    w_rready_nxt      = o_rready;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = !w_cmd_hs;
        if (w_cmd_hs) begin
          w_awaddr_nxt  = i_cmd_addr;
          w_araddr_nxt  = i_cmd_addr;
          w_wdata_nxt   = i_cmd_wdata;
          w_wstrb_nxt   = i_cmd_wstrb;
          w_awvalid_nxt = i_cmd_wr;
          w_wvalid_nxt  = i_cmd_wr;
          w_arvalid_nxt = !i_cmd_wr;
        end
      end
      // AW and W retire independently; B is only opened once neither is pending.
      S_WR_REQ: begin
        if (!w_aw_pend) w_awvalid_nxt = 1'b0;
        if (!w_w_pend)  w_wvalid_nxt  = 1'b0;
        if (!w_aw_pend && !w_w_pend) w_bready_nxt = 1'b1;
      end
      S_WR_RESP: begin
        if (w_b_hs) begin
          w_bready_nxt    = 1'b0;
          w_rsp_resp_nxt  = i_bresp;
          w_rsp_rdata_nxt = '0;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      S_RD_RESP: begin
        if (w_r_hs) begin
          w_rready_nxt    = 1'b0;
          w_rsp_resp_nxt  = i_rresp;
          w_rsp_rdata_nxt = i_rdata;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt   = 1'b0;
          w_rsp_timeout_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    // Watchdog overrides any same-cycle handshake so the timeout latency is exact.
    if (w_expire) begin
      w_awvalid_nxt     = 1'b0;
      w_wvalid_nxt      = 1'b0;
      w_bready_nxt      = 1'b0;
      w_arvalid_nxt     = 1'b0;
      w_rready_nxt      = 1'b0;
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_resp_nxt    = AXI_RESP_SLVERR;
      w_rsp_timeout_nxt = 1'b1;
      w_rsp_rdata_nxt   = '0;
    end
  end

endmodule
